// File: rtl/ahb_to_cb.sv
// ahb_to_cb: AHB subordinate that turns single AHB transfers into core-bus
// initiator transactions. One transfer is outstanding at a time; the AHB data
// phase is stretched with wait states until the core-bus response returns.
module ahb_to_cb #(
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  // AHB manager request
  input  logic [31:0] ahb_haddr_i,
  input  logic [1:0]  ahb_htrans_i,
  input  logic [2:0]  ahb_hsize_i,
  input  logic        ahb_hwrite_i,
  input  logic        ahb_hsel_i,
  input  logic [31:0] ahb_hwdata_i,
  // AHB response
  output logic        ahb_hready_o,
  output logic        ahb_hresp_o,
  output logic [31:0] ahb_hrdata_o,
  // Core-bus request
  output logic [31:0] cb_wr_addr_o,
  output logic        cb_wr_addr_valid_o,
  output logic [2:0]  cb_wr_size_o,
  output logic [31:0] cb_wr_data_o,
  output logic        cb_wr_data_valid_o,
  output logic [3:0]  cb_wr_strobe_o,
  output logic        cb_wr_resp_ready_o,
  output logic [31:0] cb_rd_addr_o,
  output logic        cb_rd_addr_valid_o,
  output logic [2:0]  cb_rd_size_o,
  output logic        cb_rd_ready_o,
  // Core-bus response
  input  logic        cb_wr_addr_ready_i,
  input  logic        cb_wr_data_ready_i,
  input  logic        cb_wr_resp_valid_i,
  input  logic [1:0]  cb_wr_resp_error_i,
  input  logic        cb_rd_addr_ready_i,
  input  logic        cb_rd_valid_i,
  input  logic [31:0] cb_rd_data_i,
  input  logic [1:0]  cb_rd_resp_i
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE, ERR1, ERR2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] hrdata_q, hrdata_d;

  logic        accept;
  logic        misaligned;
  logic        illegal;
  logic [2:0]  size_eff;
  logic [31:0] addr_eff;
  logic        aw_now;
  logic        w_now;

  // Address-phase decode: a real transfer is only taken while we drive hready high.
  assign accept     = ahb_hready_o && ahb_hsel_i &&
                      ((ahb_htrans_i == 2'b10) || (ahb_htrans_i == 2'b11));
  assign misaligned = (ahb_hsize_i > 3'd2) ||
                      ((ahb_hsize_i == 3'd1) && ahb_haddr_i[0]) ||
                      ((ahb_hsize_i == 3'd2) && (ahb_haddr_i[1:0] != 2'b00));
  assign illegal    = (ALIGN_CHECK != 0) && misaligned;
  assign size_eff   = ((ALIGN_CHECK == 0) && (ahb_hsize_i > 3'd2)) ? 3'd2 : ahb_hsize_i;
  assign addr_eff   = (ALIGN_CHECK != 0) ? ahb_haddr_i :
                      (size_eff == 3'd2) ? {ahb_haddr_i[31:2], 2'b00} :
                      (size_eff == 3'd1) ? {ahb_haddr_i[31:1], 1'b0} : ahb_haddr_i;

  // A write handshake counts as done once its ready has been seen, now or earlier.
  assign aw_now = aw_done_q || cb_wr_addr_ready_i;
  assign w_now  = w_done_q || cb_wr_data_ready_i;

  // State and capture registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      hrdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      hrdata_q  <= hrdata_d;
    end
  end

  // Next-state and capture logic; IDLE, DONE and ERR2 all accept a new address phase.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    hrdata_d  = hrdata_q;
    case (state_q)
      IDLE, DONE, ERR2: begin
        state_d = IDLE;
        if (accept) begin
          addr_d    = addr_eff;
          size_d    = size_eff;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (illegal)           state_d = ERR1;
          else if (ahb_hwrite_i) state_d = WR_REQ;
          else                   state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_now;
        w_done_d  = w_now;
        if (aw_now && w_now) state_d = WR_RSP;
      end
      WR_RSP: begin
        if (cb_wr_resp_valid_i) begin
          if (cb_wr_resp_error_i != 2'b00) begin
            state_d = ERR1;
          end else begin
            state_d  = DONE;
            hrdata_d = '0;
          end
        end
      end
      RD_REQ: begin
        if (cb_rd_addr_ready_i) state_d = RD_RSP;
      end
      RD_RSP: begin
        if (cb_rd_valid_i) begin
          hrdata_d = cb_rd_data_i;
          state_d  = (cb_rd_resp_i == 2'b00) ? DONE : ERR1;
        end
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state and capture registers only.
  always_comb begin
    ahb_hready_o       = 1'b0;
    ahb_hresp_o        = 1'b0;
    cb_wr_addr_valid_o = 1'b0;
    cb_wr_data_valid_o = 1'b0;
    cb_wr_resp_ready_o = 1'b0;
    cb_rd_addr_valid_o = 1'b0;
    cb_rd_ready_o      = 1'b0;
    cb_wr_strobe_o     = 4'hF;
    case (size_q)
      3'd0:    cb_wr_strobe_o = 4'b0001 << addr_q[1:0];
      3'd1:    cb_wr_strobe_o = 4'b0011 << {addr_q[1], 1'b0};
      default: cb_wr_strobe_o = 4'hF;
    endcase
    case (state_q)
      IDLE, DONE: ahb_hready_o = 1'b1;
      WR_REQ: begin
        cb_wr_addr_valid_o = !aw_done_q;
        cb_wr_data_valid_o = !w_done_q;
      end
      WR_RSP: cb_wr_resp_ready_o = 1'b1;
      RD_REQ: cb_rd_addr_valid_o = 1'b1;
      RD_RSP: cb_rd_ready_o      = 1'b1;
      ERR1:   ahb_hresp_o        = 1'b1;
      ERR2: begin
        ahb_hready_o = 1'b1;
        ahb_hresp_o  = 1'b1;
      end
      default: ahb_hready_o = 1'b1;
    endcase
  end

  assign ahb_hrdata_o = hrdata_q;
  assign cb_wr_addr_o = addr_q;
  assign cb_wr_size_o = size_q;
  assign cb_wr_data_o = ahb_hwdata_i;
  assign cb_rd_addr_o = addr_q;
  assign cb_rd_size_o = size_q;

endmodule

// File: tb/tb_ahb_to_cb.sv
// tb_ahb_to_cb: directed bench for ahb_to_cb. Inputs change on the falling
// edge; outputs are checked 1 time unit after the falling edge.
module tb_ahb_to_cb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic        hsel;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;
  logic [31:0] wr_addr;
  logic        wr_addr_valid;
  logic [2:0]  wr_size;
  logic [31:0] wr_data;
  logic        wr_data_valid;
  logic [3:0]  wr_strobe;
  logic        wr_resp_ready;
  logic [31:0] rd_addr;
  logic        rd_addr_valid;
  logic [2:0]  rd_size;
  logic        rd_ready;
  logic        wr_addr_ready;
  logic        wr_data_ready;
  logic        wr_resp_valid;
  logic [1:0]  wr_resp_error;
  logic        rd_addr_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ahb_to_cb #(.ALIGN_CHECK(1)) dut (
    .clk(clk), .rst(rst),
    .ahb_haddr_i(haddr), .ahb_htrans_i(htrans), .ahb_hsize_i(hsize),
    .ahb_hwrite_i(hwrite), .ahb_hsel_i(hsel), .ahb_hwdata_i(hwdata),
    .ahb_hready_o(hready), .ahb_hresp_o(hresp), .ahb_hrdata_o(hrdata),
    .cb_wr_addr_o(wr_addr), .cb_wr_addr_valid_o(wr_addr_valid), .cb_wr_size_o(wr_size),
    .cb_wr_data_o(wr_data), .cb_wr_data_valid_o(wr_data_valid), .cb_wr_strobe_o(wr_strobe),
    .cb_wr_resp_ready_o(wr_resp_ready), .cb_rd_addr_o(rd_addr),
    .cb_rd_addr_valid_o(rd_addr_valid), .cb_rd_size_o(rd_size), .cb_rd_ready_o(rd_ready),
    .cb_wr_addr_ready_i(wr_addr_ready), .cb_wr_data_ready_i(wr_data_ready),
    .cb_wr_resp_valid_i(wr_resp_valid), .cb_wr_resp_error_i(wr_resp_error),
    .cb_rd_addr_ready_i(rd_addr_ready), .cb_rd_valid_i(rd_valid),
    .cb_rd_data_i(rd_data), .cb_rd_resp_i(rd_resp)
  );

  // Drive an NONSEQ address phase.
  task automatic drive_addr(input logic [31:0] a, input logic [2:0] sz, input logic wr);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = sz; hwrite = wr;
  endtask

  // Return the address bus to an idle transfer.
  task automatic clear_addr();
    hsel = 1'b0; htrans = 2'b00; haddr = '0; hsize = 3'd0; hwrite = 1'b0;
  endtask

  // Quiet every core-bus response input.
  task automatic clear_cb();
    wr_addr_ready = 1'b0; wr_data_ready = 1'b0; wr_resp_valid = 1'b0; wr_resp_error = 2'b00;
    rd_addr_ready = 1'b0; rd_valid = 1'b0; rd_data = '0; rd_resp = 2'b00;
  endtask

  // Bounded wait for hready; an expired bound is counted as a failure.
  task automatic wait_hready(input int max_cycles, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk); #1;
      if (hready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s: hready still %b after %0d cycles, required 1", name, hready, max_cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; hwdata = '0;
    clear_addr(); clear_cb();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({hready, hresp} !== 2'b10) begin
      errors++; $display("[TB] FAIL reset_hready_hresp: got %b required 10", {hready, hresp});
    end
    checks++;
    if (hrdata !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_hrdata: got %h required 00000000", hrdata);
    end
    checks++;
    if ({wr_addr_valid, wr_data_valid, wr_resp_ready, rd_addr_valid, rd_ready} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_cb_valids: got %b required 00000",
                         {wr_addr_valid, wr_data_valid, wr_resp_ready, rd_addr_valid, rd_ready});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_word_write();
    @(negedge clk);
    wr_addr_ready = 1'b1; wr_data_ready = 1'b1; wr_resp_valid = 1'b1; wr_resp_error = 2'b00;
    drive_addr(32'h100, 3'd2, 1'b1);
    #1;
    checks++;
    if (hready !== 1'b1) begin
      errors++; $display("[TB] FAIL ww_addr_phase_hready: got %b required 1", hready);
    end
    @(negedge clk);
    clear_addr(); hwdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({hready, wr_addr_valid, wr_data_valid, rd_addr_valid} !== 4'b0110) begin
      errors++; $display("[TB] FAIL ww_req_flags: got %b required 0110",
                         {hready, wr_addr_valid, wr_data_valid, rd_addr_valid});
    end
    checks++;
    if ({wr_addr, wr_data, wr_strobe, wr_size} !== {32'h100, 32'hDEADBEEF, 4'hF, 3'd2}) begin
      errors++; $display("[TB] FAIL ww_req_payload: got addr=%h data=%h strb=%h size=%0d required addr=00000100 data=deadbeef strb=f size=2",
                         wr_addr, wr_data, wr_strobe, wr_size);
    end
    @(negedge clk); #1;
    checks++;
    if ({hready, wr_addr_valid, wr_data_valid, wr_resp_ready} !== 4'b0001) begin
      errors++; $display("[TB] FAIL ww_rsp_flags: got %b required 0001",
                         {hready, wr_addr_valid, wr_data_valid, wr_resp_ready});
    end
    @(negedge clk); #1;
    checks++;
    if ({hready, hresp, hrdata} !== {2'b10, 32'h0}) begin
      errors++; $display("[TB] FAIL ww_done: got hready=%b hresp=%b hrdata=%h required 1 0 00000000",
                         hready, hresp, hrdata);
    end
    @(negedge clk);
    clear_cb();
  endtask

  task automatic test_byte_write();
    @(negedge clk);
    wr_addr_ready = 1'b1; wr_data_ready = 1'b1; wr_resp_valid = 1'b1;
    drive_addr(32'h203, 3'd0, 1'b1);
    @(negedge clk);
    clear_addr(); hwdata = 32'hAB000000;
    #1;
    checks++;
    if ({wr_addr_valid, wr_addr, wr_strobe, wr_size} !== {1'b1, 32'h203, 4'b1000, 3'd0}) begin
      errors++; $display("[TB] FAIL bw_req: got valid=%b addr=%h strb=%b size=%0d required 1 00000203 1000 0",
                         wr_addr_valid, wr_addr, wr_strobe, wr_size);
    end
    wait_hready(8, "bw_done_timeout");
    checks++;
    if (hresp !== 1'b0) begin
      errors++; $display("[TB] FAIL bw_done_hresp: got %b required 0", hresp);
    end
    @(negedge clk);
    clear_cb();
  endtask

  task automatic test_read_stall();
    @(negedge clk);
    drive_addr(32'h40, 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) clear_addr();
      #1;
      checks++;
      if ({hready, rd_addr_valid, rd_addr, rd_size} !== {2'b01, 32'h40, 3'd2}) begin
        errors++; $display("[TB] FAIL rd_stall_cycle%0d: got hready=%b valid=%b addr=%h size=%0d required 0 1 00000040 2",
                           i, hready, rd_addr_valid, rd_addr, rd_size);
      end
    end
    @(negedge clk);
    rd_addr_ready = 1'b1; rd_valid = 1'b1; rd_data = 32'h12345678; rd_resp = 2'b00;
    @(negedge clk); #1;
    checks++;
    if ({hready, rd_addr_valid, rd_ready} !== 3'b001) begin
      errors++; $display("[TB] FAIL rd_rsp_flags: got %b required 001", {hready, rd_addr_valid, rd_ready});
    end
    @(negedge clk);
    clear_cb();
    #1;
    checks++;
    if ({hready, hresp, hrdata} !== {2'b10, 32'h12345678}) begin
      errors++; $display("[TB] FAIL rd_done: got hready=%b hresp=%b hrdata=%h required 1 0 12345678",
                         hready, hresp, hrdata);
    end
    @(negedge clk); #1;
    checks++;
    if (hrdata !== 32'h12345678) begin
      errors++; $display("[TB] FAIL rd_hrdata_hold: got %h required 12345678", hrdata);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    wr_addr_ready = 1'b1; wr_data_ready = 1'b1; wr_resp_valid = 1'b1; wr_resp_error = 2'b00;
    rd_addr_ready = 1'b1; rd_valid = 1'b1; rd_data = 32'hCAFEF00D; rd_resp = 2'b00;
    drive_addr(32'h0, 3'd2, 1'b1);
    @(negedge clk);
    clear_addr(); hwdata = 32'hA5A5A5A5;
    #1;
    checks++;
    if ({wr_addr_valid, wr_addr, wr_data} !== {1'b1, 32'h0, 32'hA5A5A5A5}) begin
      errors++; $display("[TB] FAIL b2b_write_req: got valid=%b addr=%h data=%h required 1 00000000 a5a5a5a5",
                         wr_addr_valid, wr_addr, wr_data);
    end
    @(negedge clk);
    @(negedge clk);
    drive_addr(32'h4, 3'd2, 1'b0); hwdata = '0;
    #1;
    checks++;
    if ({hready, hresp} !== 2'b10) begin
      errors++; $display("[TB] FAIL b2b_write_done: got %b required 10", {hready, hresp});
    end
    @(negedge clk);
    clear_addr();
    #1;
    checks++;
    if ({hready, wr_addr_valid, rd_addr_valid, rd_addr} !== {3'b001, 32'h4}) begin
      errors++; $display("[TB] FAIL b2b_read_req: got hready=%b wr_v=%b rd_v=%b addr=%h required 0 0 1 00000004",
                         hready, wr_addr_valid, rd_addr_valid, rd_addr);
    end
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if ({hready, hresp, hrdata} !== {2'b10, 32'hCAFEF00D}) begin
      errors++; $display("[TB] FAIL b2b_read_done: got hready=%b hresp=%b hrdata=%h required 1 0 cafef00d",
                         hready, hresp, hrdata);
    end
    @(negedge clk);
    clear_cb();
  endtask

  task automatic test_write_error();
    @(negedge clk);
    wr_addr_ready = 1'b1; wr_data_ready = 1'b1; wr_resp_valid = 1'b1; wr_resp_error = 2'b10;
    drive_addr(32'h8, 3'd2, 1'b1);
    @(negedge clk);
    clear_addr(); hwdata = 32'h11;
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if ({hready, hresp} !== 2'b01) begin
      errors++; $display("[TB] FAIL werr_first: got %b required 01", {hready, hresp});
    end
    @(negedge clk); #1;
    checks++;
    if ({hready, hresp} !== 2'b11) begin
      errors++; $display("[TB] FAIL werr_second: got %b required 11", {hready, hresp});
    end
    @(negedge clk);
    clear_cb();
    #1;
    checks++;
    if ({hready, hresp} !== 2'b10) begin
      errors++; $display("[TB] FAIL werr_after: got %b required 10", {hready, hresp});
    end
  endtask

  task automatic test_misaligned_read();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    rd_addr_ready = 1'b1;
    drive_addr(32'h2, 3'd2, 1'b0);
    @(negedge clk);
    clear_addr();
    #1;
    seen = seen | rd_addr_valid;
    checks++;
    if ({hready, hresp} !== 2'b01) begin
      errors++; $display("[TB] FAIL mis_first: got %b required 01", {hready, hresp});
    end
    @(negedge clk); #1;
    seen = seen | rd_addr_valid;
    checks++;
    if ({hready, hresp} !== 2'b11) begin
      errors++; $display("[TB] FAIL mis_second: got %b required 11", {hready, hresp});
    end
    @(negedge clk); #1;
    seen = seen | rd_addr_valid;
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("[TB] FAIL mis_no_rd_request: rd_addr_valid seen=%b required 0", seen);
    end
    clear_cb();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rd_addr_ready = 1'b1; rd_valid = 1'b0;
    drive_addr(32'h10, 3'd2, 1'b0);
    @(negedge clk);
    clear_addr();
    @(negedge clk); #1;
    checks++;
    if (rd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_in_rd_rsp: rd_ready got %b required 1", rd_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({hready, hresp, wr_addr_valid, wr_data_valid, wr_resp_ready, rd_addr_valid, rd_ready} !== 7'b1000000) begin
      errors++; $display("[TB] FAIL rstmid_idle: got %b required 1000000",
                         {hready, hresp, wr_addr_valid, wr_data_valid, wr_resp_ready, rd_addr_valid, rd_ready});
    end
    @(negedge clk);
    rd_valid = 1'b1; rd_data = 32'h0BADF00D; rd_resp = 2'b00;
    drive_addr(32'h20, 3'd2, 1'b0);
    @(negedge clk);
    clear_addr();
    wait_hready(8, "rstmid_read_timeout");
    checks++;
    if ({hresp, hrdata} !== {1'b0, 32'h0BADF00D}) begin
      errors++; $display("[TB] FAIL rstmid_read_done: got hresp=%b hrdata=%h required 0 0badf00d", hresp, hrdata);
    end
    @(negedge clk);
    clear_cb();
  endtask

  initial begin
    $display("[TB] starting ahb_to_cb bench");
    test_reset();
    test_word_write();
    test_byte_write();
    test_read_stall();
    test_back_to_back();
    test_write_error();
    test_misaligned_read();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
